// File: rtl/alu_op_issuer.sv
// alu_op_issuer: decodes an ALUOp/funct request into a 3-bit ALU control code,
// drives registered operands and control to the ALU, waits the operation's
// latency, captures the result and zero flag, and returns them over a
// valid/ready response handshake.
`timescale 1ns/1ps

module alu_op_issuer #(
  parameter int unsigned ALU_LAT = 1,  // 1..15, AND/OR/ADD/SUB/PASS
  parameter int unsigned MUL_LAT = 3   // 1..15, MUL
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  ALUOp_i,
  input  logic [5:0]  funct_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  output logic [31:0] data1_o,
  output logic [31:0] data2_o,
  output logic [2:0]  ALUCtrl_o,
  input  logic [31:0] alu_data_i,
  input  logic        alu_zero_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_zero_o,
  output logic        rsp_illegal_o,
  output logic        busy_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [2:0] CTRL_AND  = 3'b000;
  localparam logic [2:0] CTRL_OR   = 3'b001;
  localparam logic [2:0] CTRL_ADD  = 3'b010;
  localparam logic [2:0] CTRL_PASS = 3'b011;
  localparam logic [2:0] CTRL_SUB  = 3'b110;
  localparam logic [2:0] CTRL_MUL  = 3'b111;

  localparam logic [3:0] ALU_LAT_C = 4'(ALU_LAT);
  localparam logic [3:0] MUL_LAT_C = 4'(MUL_LAT);

  logic [1:0]  state_q,       state_d;
  logic [3:0]  cnt_q,         cnt_d;
  logic [31:0] data1_q,       data1_d;
  logic [31:0] data2_q,       data2_d;
  logic [2:0]  ctrl_q,        ctrl_d;
  logic        illegal_q,     illegal_d;
  logic        rsp_valid_q,   rsp_valid_d;
  logic [31:0] rsp_data_q,    rsp_data_d;
  logic        rsp_zero_q,    rsp_zero_d;
  logic        rsp_illegal_q, rsp_illegal_d;

  logic [2:0]  dec_ctrl;
  logic        dec_illegal;

  // Translate ALUOp/funct into the ALU control code and the illegal flag.
  always_comb begin
    dec_ctrl    = CTRL_PASS;
    dec_illegal = 1'b0;
    case (ALUOp_i)
      2'b00: dec_ctrl = CTRL_ADD;
      2'b01: dec_ctrl = CTRL_SUB;
      2'b11: dec_ctrl = CTRL_OR;
      2'b10: begin
        case (funct_i)
          6'b100000: dec_ctrl = CTRL_ADD;
          6'b100010: dec_ctrl = CTRL_SUB;
          6'b100100: dec_ctrl = CTRL_AND;
          6'b100101: dec_ctrl = CTRL_OR;
          6'b011000: dec_ctrl = CTRL_MUL;
          default: begin
            dec_ctrl    = CTRL_PASS;
            dec_illegal = 1'b1;
          end
        endcase
      end
      default: begin
        dec_ctrl    = CTRL_PASS;
        dec_illegal = 1'b0;
      end
    endcase
  end

  // Next-state logic: accept in IDLE, count down in WAIT, hand off in RESP.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    data1_d       = data1_q;
    data2_d       = data2_q;
    ctrl_d        = ctrl_q;
    illegal_d     = illegal_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_zero_d    = rsp_zero_q;
    rsp_illegal_d = rsp_illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          data1_d   = rs_data_i;
          data2_d   = rt_data_i;
          ctrl_d    = dec_ctrl;
          cnt_d     = (dec_ctrl == CTRL_MUL) ? MUL_LAT_C : ALU_LAT_C;
          illegal_d = dec_illegal;
          state_d   = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // A counter of 0 can only come from an illegal latency setting;
        // treat it like 1 so the FSM cannot stall for 16 cycles.
        if (cnt_q <= 4'd1) begin
          cnt_d         = 4'd0;
          rsp_data_d    = alu_data_i;
          rsp_zero_d    = alu_zero_i;
          rsp_illegal_d = illegal_q;
          rsp_valid_d   = 1'b1;
          state_d       = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset taking priority.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 4'd0;
      data1_q       <= 32'd0;
      data2_q       <= 32'd0;
      ctrl_q        <= 3'b000;
      illegal_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 32'd0;
      rsp_zero_q    <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      data1_q       <= data1_d;
      data2_q       <= data2_d;
      ctrl_q        <= ctrl_d;
      illegal_q     <= illegal_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  assign req_ready_o   = (state_q == ST_IDLE);
  assign busy_o        = (state_q != ST_IDLE);
  assign data1_o       = data1_q;
  assign data2_o       = data2_q;
  assign ALUCtrl_o     = ctrl_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign rsp_zero_o    = rsp_zero_q;
  assign rsp_illegal_o = rsp_illegal_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Testbench for alu_op_issuer: a behavioural ALU drives alu_data_i/alu_zero_i,
// and every response is compared against a reference computed directly from
// the request (ALUOp, funct, operands).
`timescale 1ns/1ps

module tb_alu_op_issuer;

  localparam int ALU_LAT = 1;
  localparam int MUL_LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready_o;
  logic [1:0]  ALUOp;
  logic [5:0]  funct;
  logic [31:0] rs;
  logic [31:0] rt;
  logic [31:0] data1_o;
  logic [31:0] data2_o;
  logic [2:0]  ALUCtrl_o;
  logic [31:0] alu_data;
  logic        alu_zero;
  logic        rsp_valid_o;
  logic        rsp_ready;
  logic [31:0] rsp_data_o;
  logic        rsp_zero_o;
  logic        rsp_illegal_o;
  logic        busy_o;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_op_issuer #(.ALU_LAT(ALU_LAT), .MUL_LAT(MUL_LAT)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .ALUOp_i(ALUOp), .funct_i(funct), .rs_data_i(rs), .rt_data_i(rt),
    .data1_o(data1_o), .data2_o(data2_o), .ALUCtrl_o(ALUCtrl_o),
    .alu_data_i(alu_data), .alu_zero_i(alu_zero),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data_o), .rsp_zero_o(rsp_zero_o),
    .rsp_illegal_o(rsp_illegal_o), .busy_o(busy_o)
  );

  // Behavioural 32-bit ALU; unknown codes pass data1 through, zero = equality.
  always_comb begin
    case (ALUCtrl_o)
      3'b000:  alu_data = data1_o & data2_o;
      3'b001:  alu_data = data1_o | data2_o;
      3'b010:  alu_data = data1_o + data2_o;
      3'b110:  alu_data = data1_o - data2_o;
      3'b111:  alu_data = data1_o * data2_o;
      default: alu_data = data1_o;
    endcase
    alu_zero = (data1_o == data2_o);
  end

  typedef struct packed {
    logic [2:0]  ctrl;
    logic [3:0]  lat;
    logic        ill;
    logic [31:0] res;
    logic        zero;
  } exp_t;

  // Reference: operation meaning -> control code, latency and result.
  function automatic exp_t model(input logic [1:0] op, input logic [5:0] f,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   kind; // 0 add, 1 sub, 2 and, 3 or, 4 mul, 5 illegal
    if (op == 2'b00)      kind = 0;
    else if (op == 2'b01) kind = 1;
    else if (op == 2'b11) kind = 3;
    else if (f == 6'd32)  kind = 0;
    else if (f == 6'd34)  kind = 1;
    else if (f == 6'd36)  kind = 2;
    else if (f == 6'd37)  kind = 3;
    else if (f == 6'd24)  kind = 4;
    else                  kind = 5;
    e.lat  = 4'(ALU_LAT);
    e.ill  = 1'b0;
    e.zero = (a == b);
    if (kind == 0)      begin e.ctrl = 3'd2; e.res = a + b; end
    else if (kind == 1) begin e.ctrl = 3'd6; e.res = a - b; end
    else if (kind == 2) begin e.ctrl = 3'd0; e.res = a & b; end
    else if (kind == 3) begin e.ctrl = 3'd1; e.res = a | b; end
    else if (kind == 4) begin e.ctrl = 3'd7; e.res = a * b; e.lat = 4'(MUL_LAT); end
    else                begin e.ctrl = 3'd3; e.res = a; e.ill = 1'b1; end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, latency, response held for 'hold' cycles, handshake.
  task automatic run_op(input logic [1:0] op, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b, input int hold);
    exp_t e;
    int   guard;
    e = model(op, f, a, b);
    guard = 0;
    while (!req_ready_o && guard < 50) begin
      tick();
      guard++;
    end
    chk("ready_before_req", 32'(req_ready_o), 32'd1);
    req_valid = 1'b1; ALUOp = op; funct = f; rs = a; rt = b;
    tick();
    req_valid = 1'b0; rs = $urandom; rt = $urandom; ALUOp = 2'($urandom);
    chk("ctrl_latched", 32'(ALUCtrl_o), 32'(e.ctrl));
    chk("data1_latched", data1_o, a);
    chk("data2_latched", data2_o, b);
    chk("busy_in_wait", 32'(busy_o), 32'd1);
    chk("ready_low_wait", 32'(req_ready_o), 32'd0);
    for (int k = 1; k < int'(e.lat); k++) begin
      tick();
      chk("rsp_valid_early", 32'(rsp_valid_o), 32'd0);
      chk("busy_in_wait", 32'(busy_o), 32'd1);
    end
    tick();
    chk("rsp_valid_at_lat", 32'(rsp_valid_o), 32'd1);
    chk("rsp_data", rsp_data_o, e.res);
    chk("rsp_zero", 32'(rsp_zero_o), 32'(e.zero));
    chk("rsp_illegal", 32'(rsp_illegal_o), 32'(e.ill));
    for (int k = 0; k < hold; k++) begin
      req_valid = 1'b1;
      tick();
      chk("rsp_valid_hold", 32'(rsp_valid_o), 32'd1);
      chk("rsp_data_hold", rsp_data_o, e.res);
      chk("rsp_zero_hold", 32'(rsp_zero_o), 32'(e.zero));
      chk("ready_low_resp", 32'(req_ready_o), 32'd0);
      chk("data1_stable_resp", data1_o, a);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_valid_cleared", 32'(rsp_valid_o), 32'd0);
    chk("ready_after_hs", 32'(req_ready_o), 32'd1);
    chk("busy_after_hs", 32'(busy_o), 32'd0);
    chk("data2_stable_idle", data2_o, b);
    chk("ctrl_stable_idle", 32'(ALUCtrl_o), 32'(e.ctrl));
  endtask

  initial begin
    int          acc_cyc[$];
    logic [31:0] exp_q[$];
    logic [1:0]  r_op;
    logic [5:0]  r_f;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [5:0]  fsel [6];
    exp_t        e;
    int          cyc;
    logic        acc;
    logic        hs;

    fsel[0] = 6'b100000; fsel[1] = 6'b100010; fsel[2] = 6'b100100;
    fsel[3] = 6'b100101; fsel[4] = 6'b011000; fsel[5] = 6'b000000;

    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    ALUOp = 2'b00; funct = 6'd0; rs = 32'd0; rt = 32'd0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_ready", 32'(req_ready_o), 32'd1);
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_data1", data1_o, 32'd0);
    chk("reset_ctrl", 32'(ALUCtrl_o), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("reset_rsp_data", rsp_data_o, 32'd0);

    // Directed cases.
    run_op(2'b10, 6'b100000, 32'd5, 32'd7, 0);
    run_op(2'b01, 6'b000000, 32'h0000_0010, 32'h0000_0010, 4);
    run_op(2'b10, 6'b011000, 32'hFFFF_FFFD, 32'd6, 0);
    run_op(2'b10, 6'b101010, 32'hCAFE_0001, 32'h1234_5678, 1);
    run_op(2'b11, 6'b000000, 32'hF0F0_0000, 32'h0000_0F0F, 0);
    run_op(2'b10, 6'b100100, 32'hFF00_FF00, 32'h0FF0_0FF0, 2);
    run_op(2'b00, 6'b000000, 32'h0000_0003, 32'h0000_0003, 0);

    // Reset during the second WAIT cycle of a MUL with a request pending.
    req_valid = 1'b1; ALUOp = 2'b10; funct = 6'b011000; rs = 32'd9; rt = 32'd9;
    tick();
    rs = 32'd11; rt = 32'd13;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; req_valid = 1'b0;
    chk("rst_mid_ready", 32'(req_ready_o), 32'd1);
    chk("rst_mid_busy", 32'(busy_o), 32'd0);
    chk("rst_mid_data1", data1_o, 32'd0);
    chk("rst_mid_data2", data2_o, 32'd0);
    chk("rst_mid_ctrl", 32'(ALUCtrl_o), 32'd0);
    chk("rst_mid_rsp_data", rsp_data_o, 32'd0);
    chk("rst_mid_rsp_zero", 32'(rsp_zero_o), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rst_mid_no_rsp", 32'(rsp_valid_o), 32'd0);
    end

    // Back-to-back ADD requests with the consumer always ready.
    rsp_ready = 1'b1; req_valid = 1'b1; ALUOp = 2'b00;
    rs = $urandom; rt = $urandom;
    for (cyc = 0; cyc < 16; cyc++) begin
      acc = req_valid && req_ready_o;
      hs  = rsp_valid_o && rsp_ready;
      if (acc) begin
        chk("no_accept_on_hs", 32'(hs), 32'd0);
        acc_cyc.push_back(cyc);
        e = model(ALUOp, funct, rs, rt);
        exp_q.push_back(e.res);
      end
      if (hs) begin
        if (exp_q.size() > 0) chk("b2b_rsp_data", rsp_data_o, exp_q.pop_front());
        else chk("b2b_unexpected_rsp", 32'd1, 32'd0);
      end
      tick();
      if (acc) begin
        rs = $urandom; rt = $urandom;
      end
    end
    req_valid = 1'b0;
    chk("b2b_accept_count", 32'(acc_cyc.size() >= 5), 32'd1);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk("b2b_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(ALU_LAT + 2));
    for (int k = 0; k < 4; k++) begin
      if (rsp_valid_o && exp_q.size() > 0) chk("b2b_rsp_data", rsp_data_o, exp_q.pop_front());
      tick();
    end
    rsp_ready = 1'b0;
    chk("b2b_drained", 32'(exp_q.size()), 32'd0);

    // Randomized requests against the reference model.
    for (int n = 0; n < 40; n++) begin
      r_op = 2'($urandom_range(0, 3));
      r_f  = fsel[$urandom_range(0, 5)];
      if ($urandom_range(0, 7) == 0) r_f = 6'($urandom);
      r_a  = $urandom;
      r_b  = ($urandom_range(0, 4) == 0) ? r_a : 32'($urandom);
      run_op(r_op, r_f, r_a, r_b, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_op_issuer.md
Name: alu_op_issuer

Overview:
Initiator-side driver for the 3-bit-control 32-bit ALU.
- Accepts a decoded-instruction request (ALUOp, funct, two operands) over a valid/ready handshake.
- Translates the request into an ALU control code and drives registered, stable operands and control into the ALU.
- Waits a per-operation latency (multiply is slower), then captures the ALU result and zero flag.
- Returns them over a valid/ready response handshake.
- Sits between the decode/register-read stage and the ALU in the multi-cycle datapath.

Parameters:
- ALU_LAT, 1, cycles from operand drive to result capture for AND/OR/ADD/SUB/pass-through (legal 1..15).
- MUL_LAT, 3, same for MUL (legal 1..15).

Ports:
- clk_i  in  1  clock; one clock, all logic on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  issuer can accept a request.
- ALUOp_i  in  2  main-control ALU op class.
- funct_i  in  6  R-type function field.
- rs_data_i  in  32  first operand.
- rt_data_i  in  32  second operand.
- data1_o  out  32  operand 1 to ALU.
- data2_o  out  32  operand 2 to ALU.
- ALUCtrl_o  out  3  control code to ALU.
- alu_data_i  in  32  ALU result.
- alu_zero_i  in  1  ALU equality flag.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  consumer accepts response.
- rsp_data_o  out  32  captured result.
- rsp_zero_o  out  1  captured zero flag.
- rsp_illegal_o  out  1  request had an undecodable funct.
- busy_o  out  1  high whenever state is not IDLE.

Behaviour:
- Control codes driven: AND 000, OR 001, ADD 010, SUB 110, MUL 111, PASS 011. The ALU's default case returns data1 for PASS.
- Decode by ALUOp_i:
  - 00: ADD.
  - 01: SUB.
  - 11: OR.
  - 10: decode funct_i:
    - 100000: ADD.
    - 100010: SUB.
    - 100100: AND.
    - 100101: OR.
    - 011000: MUL.
    - any other value: PASS, with the illegal flag set.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready_o=1. On req_valid_i=1 at a rising edge, in the same edge:
    - latch data1_o=rs_data_i, data2_o=rt_data_i, and the decoded ALUCtrl_o;
    - load the 4-bit counter with MUL_LAT if MUL, else ALU_LAT;
    - latch the illegal flag;
    - go to WAIT.
  - WAIT: req_ready_o=0. Counter decrements each edge. On the edge where the counter value is 1:
    - capture alu_data_i into rsp_data_o and alu_zero_i into rsp_zero_o;
    - drive rsp_illegal_o from the latched flag;
    - go to RESP.
  - RESP: rsp_valid_o=1, response outputs held constant. On rsp_ready_i=1 at an edge, go to IDLE and clear rsp_valid_o.
- Timing:
  - Request accepted at edge E0 gives capture at edge E0+L, where L is the selected latency.
  - rsp_valid_o is high from E0+L until the response handshake edge.
  - Minimum request-to-request spacing is L+2 cycles.
- Stability: data1_o, data2_o and ALUCtrl_o change only on request acceptance or reset. They stay stable through WAIT, RESP and the following IDLE.
- Back-to-back: req_ready_o is low in RESP, even if rsp_ready_i is high. No request is accepted on the same edge as a response handshake.
- No request arithmetic inside the block. All widths pass through; zero flag is copied, not recomputed.
- Reset (rst_i=1 at an edge), in any state:
  - state to IDLE, counter to 0;
  - data1_o, data2_o, rsp_data_o to 0; ALUCtrl_o to 000; rsp_valid_o, rsp_zero_o, rsp_illegal_o to 0;
  - req_ready_o=1 and busy_o=0 in the cycle after reset.
  - A request in flight is dropped with no response.
  - Reset has priority over a simultaneous request or response handshake.
- req_valid_i while not IDLE: ignored, no state change. The requester must hold the request.

Test Plan:
- Reset then ALUOp=10, funct=100000, rs=5, rt=7, ALU_LAT=1 -> ALUCtrl_o=010 one edge later; rsp_valid_o high next cycle; rsp_data_o=12, rsp_zero_o=0.
- ALUOp=01, rs=rt=0x0000_0010, rsp_ready_i held low 4 cycles -> ALUCtrl_o=110; rsp_data_o=0, rsp_zero_o=1 held stable all 4 cycles; req_ready_o=0 throughout.
- ALUOp=10, funct=011000, rs=-3, rt=6, MUL_LAT=3 -> busy_o high 3 WAIT cycles; rsp_data_o=0xFFFF_FFEE (-18) exactly 3 edges after acceptance.
- ALUOp=10, funct=101010 -> ALUCtrl_o=011, rsp_illegal_o=1, rsp_data_o equals rs.
- Assert rst_i in the second WAIT cycle of a MUL, with req_valid_i high -> next cycle IDLE, all outputs 0, rsp_valid_o never asserted, req_ready_o=1.
- Back-to-back requests with rsp_ready_i tied high and ALU_LAT=1 -> accepts spaced exactly 3 cycles apart; no request accepted on a response-handshake edge.
